atualiza_tabuleiro: RTL and testbench

Board-state keeper for the ultimate tic-tac-toe game. It sits directly downstream of the datapath's macro/micro registers and player flip-flop. It consumes one registered move (one-hot macro cell, one-hot micro cell, current player) and stores all 81 micro cells. It scans the affected micro board for a win or draw, updates the 9 macro cell states, and then scans the macro board to produce fim_jogo and the winner. It also provides the macro-state read port that drives escolhe_macro.

---
 rtl/atualiza_tabuleiro.sv | 232 +++++++++++++++++++++++
 tb/tb_atualiza_tabuleiro.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atualiza_tabuleiro.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : atualiza_tabuleiro
// Purpose  : Ultimate tic-tac-toe board keeper: stores the 81 micro cells,
//            resolves micro/macro wins and draws, and reports game over.
// Revision : 1.0 - initial release
// ============================================================================
module atualiza_tabuleiro #(
    parameter int N_LINHAS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        registra,
    input  logic [8:0]  macro,
    input  logic [8:0]  micro,
    input  logic        jogador,
    input  logic [3:0]  endereco_macro,
    output logic [1:0]  estado_celula,
    output logic [17:0] estado_macro,
    output logic        ocupado,
    output logic        pronto,
    output logic        jogada_invalida,
    output logic        fim_jogo,
    output logic [1:0]  vencedor
);

    localparam logic [2:0] c_ULTIMA_LINHA = 3'(N_LINHAS - 1);
    localparam logic [1:0] c_EMPATE       = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE           = 3'd0,
        S_VALIDA         = 3'd1,
        S_GRAVA          = 3'd2,
        S_CHECA_MICRO    = 3'd3,
        S_ATUALIZA_MACRO = 3'd4,
        S_CHECA_MACRO    = 3'd5,
        S_DONE           = 3'd6,
        S_FIM            = 3'd7
    } estado_t;

    // Binary index of the (last) set bit; only meaningful for one-hot input.
    function automatic logic [3:0] indice(input logic [8:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    function automatic logic um_quente(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

    // Three cell indices of a winning line, packed {c0, c1, c2}.
    function automatic logic [11:0] linha(input logic [2:0] l);
        logic [11:0] r;
        case (l)
            3'd0:    r = {4'd0, 4'd1, 4'd2};
            3'd1:    r = {4'd3, 4'd4, 4'd5};
            3'd2:    r = {4'd6, 4'd7, 4'd8};
            3'd3:    r = {4'd0, 4'd3, 4'd6};
            3'd4:    r = {4'd1, 4'd4, 4'd7};
            3'd5:    r = {4'd2, 4'd5, 4'd8};
            3'd6:    r = {4'd0, 4'd4, 4'd8};
            default: r = {4'd2, 4'd4, 4'd6};
        endcase
        return r;
    endfunction

    estado_t     r_estado;
    estado_t     w_prox;
    logic [8:0]  r_macro;
    logic [8:0]  r_micro;
    logic        r_jogador;
    logic [2:0]  r_linha;
    logic        r_vit_micro;
    logic        r_vit_macro;
    logic [1:0]  r_tab [0:80];
    logic [1:0]  r_macro_st [0:8];
    logic        r_pronto;
    logic        r_jogada_invalida;
    logic        r_fim_jogo;
    logic [1:0]  r_vencedor;

    logic [1:0]  w_jog_cod;
    logic [3:0]  w_idx_macro;
    logic [3:0]  w_idx_micro;
    logic [6:0]  w_base;
    logic [6:0]  w_end_alvo;
    logic [11:0] w_linha;
    logic [1:0]  w_mic0, w_mic1, w_mic2;
    logic [1:0]  w_mac0, w_mac1, w_mac2;
    logic        w_micro_linha;
    logic        w_macro_linha;
    logic        w_micro_cheio;
    logic        w_macro_cheio;
    logic        w_invalido;
    logic [1:0]  w_novo_macro;

    always_comb begin
        w_jog_cod   = {r_jogador, ~r_jogador};
        w_idx_macro = indice(r_macro);
        w_idx_micro = indice(r_micro);
        w_base      = 7'(w_idx_macro) * 7'd9;
        w_end_alvo  = w_base + 7'(w_idx_micro);
        w_linha     = linha(r_linha);

        w_mic0 = r_tab[w_base + 7'(w_linha[11:8])];
        w_mic1 = r_tab[w_base + 7'(w_linha[7:4])];
        w_mic2 = r_tab[w_base + 7'(w_linha[3:0])];
        w_micro_linha = (w_mic0 == w_jog_cod) && (w_mic1 == w_jog_cod) &&
                        (w_mic2 == w_jog_cod);

        // A drawn macro cell (11) never completes a line.
        w_mac0 = r_macro_st[w_linha[11:8]];
        w_mac1 = r_macro_st[w_linha[7:4]];
        w_mac2 = r_macro_st[w_linha[3:0]];
        w_macro_linha = (w_mac0 == w_mac1) && (w_mac1 == w_mac2) &&
                        ((w_mac0 == 2'b01) || (w_mac0 == 2'b10));

        w_micro_cheio = 1'b1;
        w_macro_cheio = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (r_tab[w_base + 7'(i)] == 2'b00) w_micro_cheio = 1'b0;
            if (r_macro_st[i] == 2'b00)         w_macro_cheio = 1'b0;
        end

        w_invalido = !um_quente(r_macro) || !um_quente(r_micro) ||
                     (r_macro_st[w_idx_macro] != 2'b00) ||
                     (r_tab[w_end_alvo] != 2'b00);

        if (r_vit_micro)
            w_novo_macro = w_jog_cod;
        else if (w_micro_cheio)
            w_novo_macro = c_EMPATE;
        else
            w_novo_macro = r_macro_st[w_idx_macro];
    end

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            S_IDLE:           if (registra) w_prox = S_VALIDA;
            S_VALIDA:         w_prox = w_invalido ? S_DONE : S_GRAVA;
            S_GRAVA:          w_prox = S_CHECA_MICRO;
            S_CHECA_MICRO:    if (r_linha == c_ULTIMA_LINHA) w_prox = S_ATUALIZA_MACRO;
            S_ATUALIZA_MACRO: w_prox = (w_novo_macro != r_macro_st[w_idx_macro]) ?
                                       S_CHECA_MACRO : S_DONE;
            S_CHECA_MACRO:    if (r_linha == c_ULTIMA_LINHA) w_prox = S_DONE;
            S_DONE:           w_prox = r_fim_jogo ? S_FIM : S_IDLE;
            S_FIM:            w_prox = S_FIM;
            default:          w_prox = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_estado <= S_IDLE;
        else       r_estado <= w_prox;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_macro           <= 9'd0;
            r_micro           <= 9'd0;
            r_jogador         <= 1'b0;
            r_linha           <= 3'd0;
            r_vit_micro       <= 1'b0;
            r_vit_macro       <= 1'b0;
            r_pronto          <= 1'b0;
            r_jogada_invalida <= 1'b0;
            r_fim_jogo        <= 1'b0;
            r_vencedor        <= 2'b00;
            for (int i = 0; i < 81; i++) r_tab[i] <= 2'b00;
            for (int i = 0; i < 9; i++)  r_macro_st[i] <= 2'b00;
        end else begin
            r_pronto          <= (w_prox == S_DONE);
            r_jogada_invalida <= (r_estado == S_VALIDA) && w_invalido;
            case (r_estado)
                S_IDLE: begin
                    if (registra) begin
                        r_macro     <= macro;
                        r_micro     <= micro;
                        r_jogador   <= jogador;
                        r_linha     <= 3'd0;
                        r_vit_micro <= 1'b0;
                        r_vit_macro <= 1'b0;
                    end
                end
                S_GRAVA: r_tab[w_end_alvo] <= w_jog_cod;
                S_CHECA_MICRO: begin
                    r_vit_micro <= r_vit_micro | w_micro_linha;
                    r_linha     <= r_linha + 3'd1;
                end
                S_ATUALIZA_MACRO: begin
                    r_macro_st[w_idx_macro] <= w_novo_macro;
                    r_linha                 <= 3'd0;
                end
                S_CHECA_MACRO: begin
                    r_vit_macro <= r_vit_macro | w_macro_linha;
                    r_linha     <= r_linha + 3'd1;
                    // A macro line win outranks a full-board draw.
                    if (r_linha == c_ULTIMA_LINHA) begin
                        if (r_vit_macro || w_macro_linha) begin
                            r_fim_jogo <= 1'b1;
                            r_vencedor <= w_jog_cod;
                        end else if (w_macro_cheio) begin
                            r_fim_jogo <= 1'b1;
                            r_vencedor <= c_EMPATE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        estado_macro = 18'd0;
        for (int k = 0; k < 9; k++) estado_macro[2*k +: 2] = r_macro_st[k];
    end

    assign estado_celula   = (endereco_macro < 4'd9) ? r_macro_st[endereco_macro] : 2'b00;
    assign ocupado         = (r_estado != S_IDLE) && (r_estado != S_FIM);
    assign pronto          = r_pronto;
    assign jogada_invalida = r_jogada_invalida;
    assign fim_jogo        = r_fim_jogo;
    assign vencedor        = r_vencedor;

endmodule
`default_nettype wire

// File: tb/tb_atualiza_tabuleiro.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_atualiza_tabuleiro
// Purpose  : Self-checking bench for atualiza_tabuleiro against a game model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_atualiza_tabuleiro;

    logic        clock = 1'b0;
    logic        reset;
    logic        registra;
    logic [8:0]  macro;
    logic [8:0]  micro;
    logic        jogador;
    logic [3:0]  endereco_macro;
    logic [1:0]  estado_celula;
    logic [17:0] estado_macro;
    logic        ocupado;
    logic        pronto;
    logic        jogada_invalida;
    logic        fim_jogo;
    logic [1:0]  vencedor;

    always #5 clock = ~clock;

    atualiza_tabuleiro dut (
        .clock          (clock),
        .reset          (reset),
        .registra       (registra),
        .macro          (macro),
        .micro          (micro),
        .jogador        (jogador),
        .endereco_macro (endereco_macro),
        .estado_celula  (estado_celula),
        .estado_macro   (estado_macro),
        .ocupado        (ocupado),
        .pronto         (pronto),
        .jogada_invalida(jogada_invalida),
        .fim_jogo       (fim_jogo),
        .vencedor       (vencedor)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Game model: micro board, macro states, end-of-game flags.
    int mb [81];
    int ms [9];
    int m_fim;
    int m_venc;
    int lin [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    bit chk_en     = 1'b0;
    int force_addr = -1;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_total++;
        if (atual === esperado) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
    endtask

    function automatic logic [17:0] pack_ms();
        logic [17:0] r;
        r = 18'd0;
        for (int k = 0; k < 9; k++) r[2*k +: 2] = 2'(ms[k]);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 81; i++) mb[i] = 0;
        for (int i = 0; i < 9; i++)  ms[i] = 0;
        m_fim  = 0;
        m_venc = 0;
    endtask

    task automatic model_move(input logic [8:0] ma, input logic [8:0] mi, input logic j,
                              output bit inv, output int lat);
        int  p, k, m, novo, a;
        bit  win, full;
        p = j ? 2 : 1; inv = 0; lat = 2; k = 0; m = 0;
        if ($countones(ma) != 1 || $countones(mi) != 1) inv = 1;
        else begin
            for (int i = 0; i < 9; i++) begin
                if (ma[i]) k = i;
                if (mi[i]) m = i;
            end
            if (ms[k] != 0 || mb[k*9+m] != 0) inv = 1;
        end
        if (inv) return;
        mb[k*9+m] = p;
        win = 0;
        for (int l = 0; l < 8; l++)
            if (mb[k*9+lin[l][0]] == p && mb[k*9+lin[l][1]] == p && mb[k*9+lin[l][2]] == p) win = 1;
        full = 1;
        for (int i = 0; i < 9; i++) if (mb[k*9+i] == 0) full = 0;
        novo = win ? p : (full ? 3 : 0);
        if (novo == 0) begin
            lat = 12;
            return;
        end
        ms[k] = novo;
        lat   = 20;
        win   = 0;
        for (int l = 0; l < 8; l++) begin
            a = ms[lin[l][0]];
            if ((a == 1 || a == 2) && a == ms[lin[l][1]] && a == ms[lin[l][2]]) win = 1;
        end
        full = 1;
        for (int i = 0; i < 9; i++) if (ms[i] == 0) full = 0;
        if (win) begin
            m_fim = 1; m_venc = p;
        end else if (full) begin
            m_fim = 1; m_venc = 3;
        end
    endtask

    // Per-cycle comparison while the block is at rest (IDLE or FIM).
    initial begin
        endereco_macro = 4'd0;
        forever begin
            @(negedge clock);
            if (chk_en) begin
                check("estado_macro", estado_macro, pack_ms());
                check("fim_jogo", fim_jogo, m_fim);
                check("vencedor", vencedor, m_venc);
                check("ocupado_repouso", ocupado, 0);
                check("pronto_repouso", pronto, 0);
                check("invalida_repouso", jogada_invalida, 0);
                check("estado_celula", estado_celula,
                      (endereco_macro < 9) ? ms[int'(endereco_macro)] : 0);
            end
            endereco_macro = (force_addr >= 0) ? 4'(force_addr) : 4'($urandom_range(0, 15));
        end
    end

    task automatic do_reset();
        @(negedge clock);
        chk_en   = 1'b0;
        reset    = 1'b1;
        registra = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        check("rst_estado_macro", estado_macro, 0);
        check("rst_ocupado", ocupado, 0);
        check("rst_pronto", pronto, 0);
        check("rst_invalida", jogada_invalida, 0);
        check("rst_fim", fim_jogo, 0);
        check("rst_vencedor", vencedor, 0);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        chk_en = 1'b1;
    endtask

    task automatic do_move(input logic [8:0] ma, input logic [8:0] mi, input logic j,
                           output int lat_obs);
        int n;
        bit inv_e;
        int lat_e;
        @(negedge clock);
        chk_en   = 1'b0;
        macro    = ma;
        micro    = mi;
        jogador  = j;
        registra = 1'b1;
        @(posedge clock);
        n = 1;
        @(negedge clock);
        check("ocupado_inicio", ocupado, 1);
        // Noise on inputs while busy must be ignored.
        while (!pronto && n <= 40) begin
            registra = 1'($urandom_range(0, 1));
            macro    = 9'($urandom);
            micro    = 9'($urandom);
            jogador  = 1'($urandom);
            @(posedge clock);
            n++;
            @(negedge clock);
        end
        registra = 1'b0;
        model_move(ma, mi, j, inv_e, lat_e);
        if (!pronto) begin
            check("pronto_timeout", 0, 1);
            lat_obs = -1;
            do_reset();
            return;
        end
        check("latencia", n, lat_e);
        check("jogada_invalida", jogada_invalida, inv_e);
        lat_obs = n;
        @(negedge clock);
        chk_en = 1'b1;
    endtask

    task automatic mv(input int ma, input int mi, input int j, output int lat);
        do_move(9'd1 << ma, 9'd1 << mi, 1'(j), lat);
    endtask

    task automatic fim_test();
        repeat (5) begin
            @(negedge clock);
            check("fim_ocupado", ocupado, 0);
            check("fim_pronto", pronto, 0);
            registra = 1'b1;
            macro    = 9'd1 << $urandom_range(0, 8);
            micro    = 9'd1 << $urandom_range(0, 8);
        end
        @(negedge clock);
        registra = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("fim_pronto_depois", pronto, 0);
            check("fim_ocupado_depois", ocupado, 0);
        end
    endtask

    task automatic mid_reset();
        bit visto;
        @(negedge clock);
        chk_en   = 1'b0;
        macro    = 9'd1 << $urandom_range(0, 8);
        micro    = 9'd1 << $urandom_range(0, 8);
        jogador  = 1'($urandom);
        registra = 1'b1;
        @(negedge clock);
        registra = 1'b0;
        repeat ($urandom_range(1, 15)) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        visto = 1'b0;
        repeat (25) begin
            @(negedge clock);
            if (pronto) visto = 1'b1;
        end
        check("pronto_apos_reset", visto, 0);
        chk_en = 1'b1;
    endtask

    int seq_empate [9][2] = '{'{0,0}, '{1,1}, '{2,0}, '{4,1}, '{3,0},
                              '{5,1}, '{7,0}, '{6,1}, '{8,0}};
    int seq_jogo [17][3] = '{'{0,0,0}, '{6,0,1}, '{0,1,0}, '{7,0,1}, '{0,2,0},
                             '{8,0,1}, '{1,0,0}, '{6,1,1}, '{1,1,0}, '{7,1,1},
                             '{1,2,0}, '{8,1,1}, '{2,0,0}, '{6,3,1}, '{2,1,0},
                             '{7,3,1}, '{2,2,0}};

    initial begin
        int lat;
        reset    = 1'b1;
        registra = 1'b0;
        macro    = 9'd0;
        micro    = 9'd0;
        jogador  = 1'b0;
        model_reset();
        do_reset();

        chk_en = 1'b0;
        for (int a = 0; a < 16; a++) begin
            force_addr = a;
            @(negedge clock);
            @(negedge clock);
            check("rst_estado_celula", estado_celula, 0);
        end
        force_addr = -1;
        chk_en = 1'b1;

        mv(0, 4, 0, lat);
        check("primeira_latencia", lat, 12);
        check("primeira_macro", estado_macro, 0);

        mv(0, 4, 0, lat);
        check("repetida_latencia", lat, 2);
        do_move(9'b000000011, 9'b000000001, 1'b0, lat);
        check("multi_hot_latencia", lat, 2);
        check("invalida_macro", estado_macro, 0);

        mv(4, 0, 0, lat);
        mv(1, 0, 1, lat);
        mv(4, 4, 0, lat);
        mv(3, 0, 1, lat);
        mv(4, 8, 0, lat);
        check("vitoria_micro_latencia", lat, 20);
        check("vitoria_micro_macro4", estado_macro[9:8], 2'b01);
        check("vitoria_micro_fim", fim_jogo, 0);
        force_addr = 4;
        @(negedge clock);
        @(negedge clock);
        check("celula_macro4", estado_celula, 2'b01);
        force_addr = -1;

        for (int i = 0; i < 9; i++) mv(2, seq_empate[i][0], seq_empate[i][1], lat);
        check("empate_latencia", lat, 20);
        check("empate_macro2", estado_macro[5:4], 2'b11);

        do_reset();
        for (int i = 0; i < 17; i++) mv(seq_jogo[i][0], seq_jogo[i][1], seq_jogo[i][2], lat);
        check("jogo_latencia", lat, 20);
        check("jogo_fim", fim_jogo, 1);
        check("jogo_vencedor", vencedor, 2'b01);
        fim_test();
        do_reset();
        check("pos_reset_fim", fim_jogo, 0);
        check("pos_reset_vencedor", vencedor, 0);

        for (int t = 0; t < 250; t++) begin
            if ($urandom_range(0, 29) == 0) mid_reset();
            else begin
                logic [8:0] ma, mi;
                ma = ($urandom_range(0, 9) == 0) ? 9'($urandom) : (9'd1 << $urandom_range(0, 8));
                mi = ($urandom_range(0, 9) == 0) ? 9'($urandom) : (9'd1 << $urandom_range(0, 8));
                do_move(ma, mi, 1'(t & 1), lat);
            end
            if (m_fim != 0) begin
                fim_test();
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d passed of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
